// File: rtl/bpi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// bpi_cmd_sequencer
//
// Upstream stage of the BPI flash interface. Pops 16-bit command words from a
// first-word-fall-through command FIFO, decodes them, and holds the flash word
// address and write data. For each flash word it issues one EXECUTE pulse
// (with READ or WRITE) to the interface FSM. Read data strobed by LOAD is
// pushed into a readback FIFO.
//
// Command word: [4:0] opcode, [15:5] payload P.
//   0x02 NOOP
//   0x17 LOAD_ADDR  ADDR[22:16] = P[6:0], next word -> ADDR[15:0]
//   0x0C WRITE_1    next word -> WDATA, one write at ADDR
//   0x0E WRITE_N    P+1 data words, one write each, ADDR+1 after each
//   0x04 READ_1     one read at ADDR
//   0x06 READ_N     P+1 reads, ADDR+1 after each
//   other           discarded, ERR_OPCODE set
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   CMD_DATA/EMPTY/RD command FIFO head word, empty flag, pop strobe
//   EXECUTE           one-cycle start pulse to the interface FSM
//   READ/WRITE        request direction, held from EXECUTE until BUSY falls
//   BUSY              interface FSM busy
//   LOAD/FLASH_DQ_IN  read data strobe and data from the interface FSM
//   ADDR/WDATA        current flash word address and write data
//   RBK_DATA/WE/FULL  readback FIFO data, write strobe, full flag
//   SEQ_BUSY          high whenever the sequencer is not idle
//   ERR_OPCODE        sticky: undefined opcode seen
//   ERR_ACK           sticky: BUSY never rose after an EXECUTE
// -----------------------------------------------------------------------------
module bpi_cmd_sequencer #(
    parameter int ADDR_W      = 23,
    parameter int CNT_W       = 11,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [15:0]       CMD_DATA,
    input  logic              CMD_EMPTY,
    output logic              CMD_RD,
    output logic              EXECUTE,
    output logic              READ,
    output logic              WRITE,
    input  logic              BUSY,
    input  logic              LOAD,
    input  logic [15:0]       FLASH_DQ_IN,
    output logic [ADDR_W-1:0] ADDR,
    output logic [15:0]       WDATA,
    output logic [15:0]       RBK_DATA,
    output logic              RBK_WE,
    input  logic              RBK_FULL,
    output logic              SEQ_BUSY,
    output logic              ERR_OPCODE,
    output logic              ERR_ACK
);

    localparam logic [4:0] OP_NOOP      = 5'h02;
    localparam logic [4:0] OP_LOAD_ADDR = 5'h17;
    localparam logic [4:0] OP_WRITE_1   = 5'h0C;
    localparam logic [4:0] OP_WRITE_N   = 5'h0E;
    localparam logic [4:0] OP_READ_1    = 5'h04;
    localparam logic [4:0] OP_READ_N    = 5'h06;

    localparam int             ACK_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_GET_ARG,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_NEXT
    } state_t;

    state_t            state_q,   state_d;
    logic [4:0]        op_q,      op_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [15:0]       wdata_q,   wdata_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
    logic              rd_q,      rd_d;
    logic              wr_q,      wr_d;
    logic              err_op_q,  err_op_d;
    logic              err_ack_q, err_ack_d;
    logic              rbk_we_q;
    logic [15:0]       rbk_data_q;

    logic              cmd_rd;
    logic              execute;
    logic [4:0]        cmd_op;
    logic              op_is_read;
    logic              op_is_burst;

    assign cmd_op      = CMD_DATA[4:0];
    assign op_is_read  = (op_q == OP_READ_1) || (op_q == OP_READ_N);
    assign op_is_burst = (op_q == OP_READ_N) || (op_q == OP_WRITE_N);

    // Next-state and control decode.
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        ack_cnt_d = ack_cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        err_op_d  = err_op_q;
        err_ack_d = err_ack_q;
        cmd_rd    = 1'b0;
        execute   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!CMD_EMPTY) state_d = S_FETCH;
            end

            S_FETCH: begin
                if (!CMD_EMPTY) begin
                    cmd_rd = 1'b1;
                    op_d   = cmd_op;
                    case (cmd_op)
                        OP_NOOP: state_d = S_IDLE;
                        OP_LOAD_ADDR: begin
                            addr_d[ADDR_W-1:16] = CMD_DATA[5 +: ADDR_W-16];
                            state_d             = S_GET_ARG;
                        end
                        OP_WRITE_1: begin
                            cnt_d   = '0;
                            state_d = S_GET_ARG;
                        end
                        OP_WRITE_N: begin
                            cnt_d   = CMD_DATA[5 +: CNT_W];
                            state_d = S_GET_ARG;
                        end
                        OP_READ_1: begin
                            cnt_d   = '0;
                            state_d = S_ISSUE;
                        end
                        OP_READ_N: begin
                            cnt_d   = CMD_DATA[5 +: CNT_W];
                            state_d = S_ISSUE;
                        end
                        default: begin
                            err_op_d = 1'b1;
                            state_d  = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end

            // Argument word: low address half for LOAD_ADDR, data otherwise.
            S_GET_ARG: begin
                if (!CMD_EMPTY) begin
                    cmd_rd = 1'b1;
                    if (op_q == OP_LOAD_ADDR) begin
                        addr_d[15:0] = CMD_DATA;
                        state_d      = S_IDLE;
                    end else begin
                        wdata_d = CMD_DATA;
                        state_d = S_ISSUE;
                    end
                end
            end

            // Reads are held back while the readback FIFO cannot take data.
            S_ISSUE: begin
                if (!(op_is_read && RBK_FULL)) begin
                    execute   = 1'b1;
                    rd_d      = op_is_read;
                    wr_d      = !op_is_read;
                    ack_cnt_d = '0;
                    state_d   = S_WAIT_ACK;
                end
            end

            // A timeout abandons the rest of the command; unread burst words
            // stay in the command FIFO.
            S_WAIT_ACK: begin
                if (BUSY) begin
                    state_d = S_WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    err_ack_d = 1'b1;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
                end
            end

            S_WAIT_DONE: begin
                if (!BUSY) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                if (op_is_burst) addr_d = addr_q + ADDR_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (op_q == OP_WRITE_N) ? S_GET_ARG : S_ISSUE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            op_q       <= 5'h0;
            addr_q     <= '0;
            wdata_q    <= 16'h0;
            cnt_q      <= '0;
            ack_cnt_q  <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            err_op_q   <= 1'b0;
            err_ack_q  <= 1'b0;
            rbk_we_q   <= 1'b0;
            rbk_data_q <= 16'h0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            ack_cnt_q  <= ack_cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            err_op_q   <= err_op_d;
            err_ack_q  <= err_ack_d;
            // Readback capture is independent of the sequencer state.
            rbk_we_q   <= LOAD;
            if (LOAD) rbk_data_q <= FLASH_DQ_IN;
        end
    end

    // The direction flags register one cycle late, so the EXECUTE cycle
    // drives READ/WRITE directly from the decoded opcode.
    assign CMD_RD     = cmd_rd;
    assign EXECUTE    = execute;
    assign READ       = rd_q | (execute & op_is_read);
    assign WRITE      = wr_q | (execute & ~op_is_read);
    assign ADDR       = addr_q;
    assign WDATA      = wdata_q;
    assign RBK_DATA   = rbk_data_q;
    assign RBK_WE     = rbk_we_q;
    assign SEQ_BUSY   = (state_q != S_IDLE);
    assign ERR_OPCODE = err_op_q;
    assign ERR_ACK    = err_ack_q;

endmodule

// File: tb/tb_bpi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bpi_cmd_sequencer
//
// Scoreboard bench for bpi_cmd_sequencer. Directed command sequences push the
// expected EXECUTE transactions and readback words into queues; a monitor on
// the falling clock edge pops and compares whenever the DUT presents EXECUTE
// or RBK_WE. A small model stands in for the command FIFO and another for the
// interface FSM (BUSY/LOAD handshake).
// -----------------------------------------------------------------------------
module tb_bpi_cmd_sequencer;

    localparam int ADDR_W = 23;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       cmd_data = 16'h0;
    logic              cmd_empty = 1'b1;
    logic              cmd_rd;
    logic              execute;
    logic              read;
    logic              write;
    logic              busy = 1'b0;
    logic              load = 1'b0;
    logic [15:0]       flash_dq_in = 16'h0;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic [15:0]       rbk_data;
    logic              rbk_we;
    logic              rbk_full = 1'b0;
    logic              seq_busy;
    logic              err_opcode;
    logic              err_ack;

    bpi_cmd_sequencer dut (
        .CLK        (clk),
        .RST        (rst),
        .CMD_DATA   (cmd_data),
        .CMD_EMPTY  (cmd_empty),
        .CMD_RD     (cmd_rd),
        .EXECUTE    (execute),
        .READ       (read),
        .WRITE      (write),
        .BUSY       (busy),
        .LOAD       (load),
        .FLASH_DQ_IN(flash_dq_in),
        .ADDR       (addr),
        .WDATA      (wdata),
        .RBK_DATA   (rbk_data),
        .RBK_WE     (rbk_we),
        .RBK_FULL   (rbk_full),
        .SEQ_BUSY   (seq_busy),
        .ERR_OPCODE (err_opcode),
        .ERR_ACK    (err_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              is_wr;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       wdata;
    } exec_t;

    exec_t       exp_exec_q[$];
    logic [15:0] exp_rbk_q[$];
    logic [15:0] rd_data_q[$];
    logic [15:0] cmd_q[$];

    int n_checks   = 0;
    int n_errors   = 0;
    int exec_count = 0;
    int pop_count  = 0;
    bit noack      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event did not match the scoreboard", name);
    endtask

    task automatic refresh_fifo();
        cmd_empty = (cmd_q.size() == 0);
        cmd_data  = cmd_empty ? 16'h0 : cmd_q[0];
    endtask

    task automatic push_cmd(input logic [15:0] w);
        cmd_q.push_back(w);
        refresh_fifo();
    endtask

    task automatic exp_exec(input logic is_wr, input logic [ADDR_W-1:0] a, input logic [15:0] d);
        exec_t e;
        e.is_wr = is_wr;
        e.addr  = a;
        e.wdata = d;
        exp_exec_q.push_back(e);
    endtask

    // Stimulus changes land away from both clock edges.
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Stimulus-side sampling, after the monitor has run for this edge.
    task automatic nsample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            nsample();
            if (!seq_busy && cmd_q.size() == 0 && !busy) return;
        end
        fail_event({name, "_idle_timeout"});
    endtask

    task automatic wait_exec(input string name, input int target);
        for (int i = 0; i < 400; i++) begin
            nsample();
            if (exec_count >= target) return;
        end
        fail_event({name, "_exec_timeout"});
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_ctl"},
              {56'h0, cmd_rd, execute, read, write, rbk_we, seq_busy, err_opcode, err_ack}, 64'h0);
        check({name, "_addr"}, 64'(addr), 64'h0);
        check({name, "_wdata"}, 64'(wdata), 64'h0);
        check({name, "_rbk_data"}, 64'(rbk_data), 64'h0);
    endtask

    task automatic check_queues_empty(input string name);
        check({name, "_exec_left"}, 64'(exp_exec_q.size()), 64'h0);
        check({name, "_rbk_left"}, 64'(exp_rbk_q.size()), 64'h0);
    endtask

    // Command FIFO model: a pop requested in a cycle is applied just after
    // the rising edge that ends that cycle.
    initial begin : fifo_model
        bit rd;
        forever begin
            @(negedge clk);
            rd = cmd_rd;
            @(posedge clk);
            #1;
            if (rd) begin
                if (cmd_q.size() == 0) begin
                    fail_event("pop_while_empty");
                end else begin
                    void'(cmd_q.pop_front());
                    pop_count++;
                end
                refresh_fifo();
            end
        end
    end

    // Interface FSM model: BUSY one cycle after EXECUTE, LOAD the next cycle
    // for reads, BUSY low the cycle after that. Silent when noack is set.
    initial begin : iface_model
        bit is_rd;
        forever begin
            @(negedge clk);
            if (execute && !noack) begin
                is_rd = read;
                @(posedge clk);
                #1;
                busy = 1'b1;
                @(posedge clk);
                #1;
                if (is_rd && !rst) begin
                    load        = 1'b1;
                    flash_dq_in = (rd_data_q.size() != 0) ? rd_data_q.pop_front() : 16'hDEAD;
                end
                @(posedge clk);
                #1;
                load = 1'b0;
                busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    exec_t       mon_e;
    logic [15:0] mon_r;
    always @(negedge clk) begin
        if (execute) begin
            exec_count++;
            if (exp_exec_q.size() == 0) begin
                fail_event("unexpected_execute");
            end else begin
                mon_e = exp_exec_q.pop_front();
                check("exec_addr", 64'(addr), 64'(mon_e.addr));
                check("exec_dir", {62'h0, read, write}, mon_e.is_wr ? 64'h1 : 64'h2);
                if (mon_e.is_wr) check("exec_wdata", 64'(wdata), 64'(mon_e.wdata));
            end
        end
        if (rbk_we) begin
            if (exp_rbk_q.size() == 0) begin
                fail_event("unexpected_rbk_we");
            end else begin
                mon_r = exp_rbk_q.pop_front();
                check("rbk_data", 64'(rbk_data), 64'(mon_r));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base;
        int pbase;

        // Reset state.
        nsample();
        nsample();
        check_reset_values("reset");
        tick();
        rst = 1'b0;

        // LOAD_ADDR 0x123456 then WRITE_1 0xBEEF.
        tick();
        exp_exec(1'b1, 23'h123456, 16'hBEEF);
        push_cmd(16'h0257);
        push_cmd(16'h3456);
        push_cmd(16'h000C);
        push_cmd(16'hBEEF);
        wait_idle("write_1");
        check("write_1_addr", 64'(addr), 64'h123456);
        check_queues_empty("write_1");

        // READ_N P=3 across the address wrap.
        tick();
        for (int i = 0; i < 4; i++) begin
            rd_data_q.push_back(16'hA0 + 16'(i));
            exp_rbk_q.push_back(16'hA0 + 16'(i));
        end
        exp_exec(1'b0, 23'h7FFFFE, 16'h0);
        exp_exec(1'b0, 23'h7FFFFF, 16'h0);
        exp_exec(1'b0, 23'h000000, 16'h0);
        exp_exec(1'b0, 23'h000001, 16'h0);
        push_cmd(16'h0FF7);
        push_cmd(16'hFFFE);
        push_cmd(16'h0066);
        wait_idle("read_n_wrap");
        check("read_n_wrap_addr", 64'(addr), 64'h2);
        check_queues_empty("read_n_wrap");

        // WRITE_N P=1 with the second data word arriving late.
        tick();
        base = exec_count;
        exp_exec(1'b1, 23'h000100, 16'h1111);
        exp_exec(1'b1, 23'h000101, 16'h2222);
        push_cmd(16'h0017);
        push_cmd(16'h0100);
        push_cmd(16'h002E);
        push_cmd(16'h1111);
        wait_exec("write_n_first", base + 1);
        for (int i = 0; i < 20; i++) nsample();
        check("write_n_stall_execs", 64'(exec_count - base), 64'h1);
        check("write_n_stall_busy", 64'(seq_busy), 64'h1);
        tick();
        push_cmd(16'h2222);
        wait_idle("write_n");
        check("write_n_execs", 64'(exec_count - base), 64'h2);
        check("write_n_addr", 64'(addr), 64'h102);
        check_queues_empty("write_n");

        // Undefined opcode followed by NOOP.
        tick();
        base  = exec_count;
        pbase = pop_count;
        push_cmd(16'h001F);
        push_cmd(16'h0002);
        wait_idle("bad_opcode");
        check("bad_opcode_err", 64'(err_opcode), 64'h1);
        check("bad_opcode_pops", 64'(pop_count - pbase), 64'h2);
        check("bad_opcode_execs", 64'(exec_count - base), 64'h0);

        // READ_1 held back by a full readback FIFO.
        tick();
        base     = exec_count;
        rbk_full = 1'b1;
        rd_data_q.push_back(16'h5A5A);
        exp_rbk_q.push_back(16'h5A5A);
        exp_exec(1'b0, 23'h000102, 16'h0);
        push_cmd(16'h0004);
        for (int i = 0; i < 10; i++) nsample();
        check("rbk_full_execs", 64'(exec_count - base), 64'h0);
        check("rbk_full_busy", 64'(seq_busy), 64'h1);
        tick();
        rbk_full = 1'b0;
        wait_idle("rbk_full");
        check("rbk_full_addr", 64'(addr), 64'h102);
        check_queues_empty("rbk_full");

        // BUSY never rises: ERR_ACK after the timeout.
        tick();
        noack = 1'b1;
        exp_exec(1'b1, 23'h000102, 16'h7777);
        push_cmd(16'h000C);
        push_cmd(16'h7777);
        begin : find_exec
            for (int i = 0; i < 50; i++) begin
                nsample();
                if (execute) disable find_exec;
            end
            fail_event("ack_timeout_exec_timeout");
        end
        for (int i = 0; i < 8; i++) nsample();
        check("ack_err_early", 64'(err_ack), 64'h0);
        nsample();
        check("ack_err_set", 64'(err_ack), 64'h1);
        check("ack_rw_clear", {62'h0, read, write}, 64'h0);
        check("ack_seq_idle", 64'(seq_busy), 64'h0);
        check_queues_empty("ack_timeout");
        noack = 1'b0;

        // Reset in the middle of READ_N P=3.
        tick();
        base = exec_count;
        for (int i = 0; i < 4; i++) begin
            rd_data_q.push_back(16'hB0 + 16'(i));
            exp_rbk_q.push_back(16'hB0 + 16'(i));
            exp_exec(1'b0, 23'h000102 + 23'(i), 16'h0);
        end
        push_cmd(16'h0066);
        wait_exec("reset_burst", base + 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        nsample();
        check_reset_values("mid_reset");
        exp_exec_q.delete();
        exp_rbk_q.delete();
        rd_data_q.delete();
        for (int i = 0; i < 3; i++) nsample();
        tick();
        rst = 1'b0;

        // Normal operation after reset starts from ADDR 0.
        tick();
        exp_exec(1'b1, 23'h000000, 16'hCAFE);
        push_cmd(16'h000C);
        push_cmd(16'hCAFE);
        wait_idle("post_reset");
        check("post_reset_addr", 64'(addr), 64'h0);
        check_queues_empty("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
